muldiv_hilo: RTL and testbench
==============================

Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the combinational ALU and receives the same x/y operands from the ID/EX latch.
- Handles MULT/MULTU/DIV/DIVU over multiple cycles and holds the results for MFHI/MFLO.
- Its busy output drives the pipeline stall logic; the MTHI/MTLO write path also lands here.

Parameters:
- DIV_ZERO_LO, 32'hFFFF_FFFF, value written to LO on divide by zero.
- ITER, 32, iteration cycles for the shift-add multiply and restoring divide; legal value is 32 only, exposed for the bench.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- x  input  32  multiplicand / dividend
- y  input  32  multiplier / divisor
- we_hi  input  1  MTHI write enable
- we_lo  input  1  MTLO write enable
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in flight; pipeline stalls on MFHI/MFLO/new mul-div while high
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
- dz  output  1  sticky divide-by-zero flag for the last operation
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0. Reset mid-operation aborts the operation; no HI/LO write occurs.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch op, |x|, |y| (absolute values only for signed ops), the sign bits, and an iteration counter of 0. Go to CALC. busy=1 from the next cycle.
- Divide by zero (DIV/DIVU, y==0) skips CALC. Go directly to DONE with lo=DIV_ZERO_LO, hi=x, dz=1. Every other accepted operation clears dz.
- CALC, multiply: one radix-2 shift-add step per cycle into a 64-bit accumulator.
- CALC, divide: one restoring step per cycle; shift {rem,quo} left 1, subtract |y| when no borrow, set quotient bit.
- CALC leaves for FIX when the counter reaches ITER-1 (ITER cycles in CALC).
- FIX (1 cycle):
  - Signed multiply: negate the 64-bit product if sign(x)^sign(y).
  - Signed divide: negate the quotient if sign(x)^sign(y); negate the remainder if sign(x) (remainder takes the dividend's sign).
  - Write {hi,lo}=product, or lo=quotient, hi=remainder. Go to DONE.
- DONE (1 cycle): done=1, busy=0 combinationally in this state, return to IDLE.
- Latency: start sampled at edge N; done high in cycle N+ITER+2 (34 cycles).
- start while busy is ignored; no queuing.
- -2^31 / -1 (signed) gives lo=32'h8000_0000, hi=0, dz=0; no trap.
- MTHI/MTLO:
  - In IDLE or DONE, we_hi/we_lo update hi/lo at the next edge.
  - Both may be written in the same cycle.
  - Ignored while state is CALC or FIX.
  - If start and we_* coincide in IDLE, the we_* write happens and the operation later overwrites it.
- hi/lo change only at FIX, on the divide-by-zero path, on an MTHI/MTLO write, or at reset.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU bypass CALC. A single-cycle signed/unsigned 64-bit multiply is written in the cycle after start; next state is DONE, so done is high at N+2 and busy lasts 1 cycle. Divide is unchanged.
- Undefined: the multiply uses the iterative path, 34-cycle latency.

Test Plan:
- Reset asserted mid-DIV (cycle 10) -> next cycle busy=0, done=0, hi=lo=0, dz=0. A following start runs normally.
- MULT x=32'hFFFF_FFFE (-2), y=3 -> done at N+34, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. With MULDIV_FAST_MUL_EN: done at N+2, same values.
- MULTU x=y=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV x=-7 (32'hFFFF_FFF9), y=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU same operands -> lo=32'h7FFF_FFFC, hi=1.
- DIV x=32'h8000_0000, y=-1 -> lo=32'h8000_0000, hi=0, dz=0. DIVU x=5, y=0 -> done at N+2, lo=32'hFFFF_FFFF, hi=5, dz=1.
- we_hi=1, wdata=32'hA5A5_A5A5 during CALC -> hi unchanged and final result written. Same write in IDLE -> hi=32'hA5A5_A5A5 next cycle. start pulsed during busy -> ignored, only one done pulse.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to get a single-cycle multiply. Divide stays iterative.
module muldiv_hilo #(
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF,
    parameter int          ITER        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // Handshake: start is a one-cycle request that is accepted only while the
    // unit is idle. busy stays high from the cycle after acceptance until the
    // result is written. done then pulses for one cycle with HI/LO valid.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW       = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    logic [1:0]    state;
    logic [1:0]    op_q;
    logic          sx, sy;
    logic [31:0]   xa, ya;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;

    logic          in_signed;
    logic [31:0]   x_abs, y_abs;
    logic          is_div, is_signed, neg_res, dz_hit;
    logic [32:0]   mul_sum;
    logic [63:0]   mul_next;
    logic [32:0]   div_sh;
    logic          no_borrow;
    logic [31:0]   div_diff;
    logic [63:0]   div_next;
    logic [63:0]   prod;
    logic [31:0]   quo, rem, x_back;

    assign in_signed = ~op[0];
    assign x_abs     = (in_signed && x[31]) ? -x : x;
    assign y_abs     = (in_signed && y[31]) ? -y : y;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign neg_res   = is_signed & (sx ^ sy);
    assign dz_hit    = is_div && (ya == 32'd0);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, xa} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifts left.
    assign div_sh    = {acc[63:32], acc[31]};
    assign no_borrow = div_sh >= {1'b0, ya};
    assign div_diff  = div_sh[31:0] - ya;
    assign div_next  = no_borrow ? {div_diff, acc[30:0], 1'b1}
                                 : {div_sh[31:0], acc[30:0], 1'b0};

    assign prod   = neg_res ? -acc : acc;
    assign quo    = neg_res ? -acc[31:0] : acc[31:0];
    assign rem    = (is_signed && sx) ? -acc[63:32] : acc[63:32];
    assign x_back = sx ? -xa : xa;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    logic [63:0] fast_res;
    assign fast_prod = {32'd0, xa} * {32'd0, ya};
    assign fast_res  = neg_res ? -fast_prod : fast_prod;
`endif

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= 2'd0;
            sx    <= 1'b0;
            sy    <= 1'b0;
            xa    <= 32'd0;
            ya    <= 32'd0;
            cnt   <= '0;
            acc   <= 64'd0;
            dz    <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            // MTHI/MTLO never collide with a result write: results land in CALC/FIX only.
            if (state == S_IDLE || state == S_DONE) begin
                if (we_hi) hi <= wdata;
                if (we_lo) lo <= wdata;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sx    <= in_signed & x[31];
                        sy    <= in_signed & y[31];
                        xa    <= x_abs;
                        ya    <= y_abs;
                        cnt   <= '0;
                        dz    <= 1'b0;
                        acc   <= op[1] ? {32'd0, x_abs} : {32'd0, y_abs};
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt == '0 && dz_hit) begin
                        lo    <= DIV_ZERO_LO;
                        hi    <= x_back;
                        dz    <= 1'b1;
                        state <= S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (cnt == '0 && !is_div) begin
                        {hi, lo} <= fast_res;
                        state    <= S_DONE;
                    end
`endif
                    else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) {hi, lo} <= {rem, quo};
                    else        {hi, lo} <= prod;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed and random MULT/DIV against an
// arithmetic reference model, plus MTHI/MTLO, reset-abort and busy-start cases.
module tb_muldiv_hilo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [64:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int DZ_LAT  = 2;

    muldiv_hilo dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {dz, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'b01: begin p = ua * ub; return {1'b0, p}; end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                p = ua / ub;
                q = longint'(p);
                p = ua % ub;
                r = longint'(p);
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (!o[1]) return MUL_LAT;
        if (b == 32'd0) return DZ_LAT;
        return DIV_LAT;
    endfunction

    // Driver: pulse start, wait for done (bounded). lat = cycles to done, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        op = o; x = a; y = b; start = 1'b1;
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, dz, hi, lo);
        end
    endtask

    task automatic test_mult();
        logic [31:0] ta[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
        logic [31:0] tb[4] = '{32'd3,         32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
        logic [1:0]  to[4] = '{2'b00,         2'b01,         2'b00,         2'b01};
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] e;
        int lat;
        bit bok;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin o = to[i]; a = ta[i]; b = tb[i]; end
            else begin o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
            exp_q.push_back(model(o, a, b));
            run_op(o, a, b, lat, bok);
            e = exp_q.pop_front();
            checks++;
            if (lat !== exp_lat(o, b) || !bok) begin
                errors++;
                $display("FAIL mult_latency[%0d]: got %0d busy_ok=%b, want %0d", i, lat, bok, exp_lat(o, b));
            end
            checks++;
            if ({dz, hi, lo} !== e) begin
                errors++;
                $display("FAIL mult_result[%0d] op=%0d x=%h y=%h: got dz=%b %h_%h, want dz=%b %h_%h",
                         i, o, a, b, dz, hi, lo, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta[5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7,         32'd5};
        logic [31:0] tb[5] = '{32'd2,         32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        logic [1:0]  to[5] = '{2'b10,         2'b11,         2'b10,         2'b10,         2'b11};
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] e;
        int lat;
        bit bok;
        for (int i = 0; i < 24; i++) begin
            if (i < 5) begin o = to[i]; a = ta[i]; b = tb[i]; end
            else begin
                o = 2'($urandom_range(2, 3));
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = $urandom_range(1, 15);
                    2: b = -$urandom_range(1, 15);
                    default: b = $urandom;
                endcase
            end
            exp_q.push_back(model(o, a, b));
            run_op(o, a, b, lat, bok);
            e = exp_q.pop_front();
            checks++;
            if (lat !== exp_lat(o, b) || !bok) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d busy_ok=%b, want %0d", i, lat, bok, exp_lat(o, b));
            end
            checks++;
            if ({dz, hi, lo} !== e) begin
                errors++;
                $display("FAIL div_result[%0d] op=%0d x=%h y=%h: got dz=%b %h_%h, want dz=%b %h_%h",
                         i, o, a, b, dz, hi, lo, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] old_hi, old_lo;
        logic [64:0] e;
        int lat;
        bit bok;
        // IDLE single writes, then both together
        @(negedge clk);
        old_lo = lo;
        we_hi = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        we_hi = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== old_lo) begin
            errors++;
            $display("FAIL mthi_idle: got hi=%h lo=%h, want hi=a5a5a5a5 lo=%h", hi, lo, old_lo);
        end
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi_mtlo_both: got hi=%h lo=%h, want 12345678 both", hi, lo);
        end
        // write attempt during CALC is dropped
        e = model(2'b01, 32'd7, 32'd9);
        op = 2'b01; x = 32'd7; y = 32'd9; start = 1'b1;
        old_hi = hi;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin we_hi = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (k == 6) begin
                we_hi = 1'b0;
                checks++;
                if (hi !== old_hi) begin
                    errors++;
                    $display("FAIL mthi_in_calc: got hi=%h, want %h", hi, old_hi);
                end
            end
            if (done) begin lat = k; break; end
        end
        we_hi = 1'b0;
        checks++;
        if (lat !== MUL_LAT || {dz, hi, lo} !== e) begin
            errors++;
            $display("FAIL mult_after_mthi: got lat=%0d %h_%h, want lat=%0d %h_%h", lat, hi, lo, MUL_LAT, e[63:32], e[31:0]);
        end
        // write in DONE cycle is accepted (only if DONE was reached)
        if (lat > 0) begin
            old_hi = hi;
            we_lo = 1'b1; wdata = 32'hCAFE_F00D;
            @(negedge clk);
            we_lo = 1'b0;
            checks++;
            if (lo !== 32'hCAFE_F00D || hi !== old_hi) begin
                errors++;
                $display("FAIL mtlo_in_done: got hi=%h lo=%h, want hi=%h lo=cafef00d", hi, lo, old_hi);
            end
        end
        // start and MTLO together: write lands, result overwrites later
        @(negedge clk);
        op = 2'b11; x = 32'd100; y = 32'd7; start = 1'b1; we_lo = 1'b1; wdata = 32'h0BAD_BEEF;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        checks++;
        if (lo !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL start_with_mtlo_write: got lo=%h, want 0badbeef", lo);
        end
        lat = -1;
        for (int k = 2; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat !== DIV_LAT || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL start_with_mtlo_result: got lat=%0d hi=%h lo=%h, want lat=%0d hi=2 lo=e", lat, hi, lo, DIV_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] e;
        int pulses;
        e = model(2'b00, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        op = 2'b00; x = 32'hFFFF_FFFE; y = 32'd3; start = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1 || k == 5) begin
                op = 2'b11; x = 32'd50; y = 32'd0; start = 1'b1;
            end
            if (done) pulses++;
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL start_while_busy_pulses: got %0d done pulses, want 1", pulses);
        end
        checks++;
        if ({dz, hi, lo} !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy_result: got dz=%b %h_%h busy=%b, want dz=0 %h_%h busy=0",
                     dz, hi, lo, busy, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [64:0] e;
        int lat;
        bit bok;
        @(negedge clk);
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h5555_AAAA;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        op = 2'b10; x = 32'h7000_0000; y = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_div: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, dz, hi, lo);
        end
        e = model(2'b10, 32'hFFFF_FF9C, 32'd7);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, lat, bok);
        checks++;
        if (lat !== DIV_LAT || !bok || {dz, hi, lo} !== e) begin
            errors++;
            $display("FAIL div_after_reset: got lat=%0d dz=%b %h_%h, want lat=%0d dz=0 %h_%h",
                     lat, dz, hi, lo, DIV_LAT, e[63:32], e[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
